// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM encoding,
// frame-length width and the running-checksum helper.
package imem_loader_pkg;

    localparam int LEN_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_SUM    = 3'd4
    } state_t;

    // Modulo-256 accumulate; overflow wraps silently by design.
    function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] val);
        logic [7:0] res;
        res = acc + val;
        return res;
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Little-endian byte-to-word assembly: first accepted byte lands in bits 7:0,
// the fourth byte completes the word, which is presented combinationally.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_done
);

    logic [1:0]  lane_r;
    logic [23:0] shift_r;

    // Lane counter and shift register for the three lower bytes of a word
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_r  <= 2'd0;
            shift_r <= 24'd0;
        end else if (clr) begin
            lane_r  <= 2'd0;
            shift_r <= 24'd0;
        end else if (byte_valid) begin
            lane_r  <= lane_r + 2'd1;
            shift_r <= {byte_data, shift_r[23:8]};
        end else begin
            lane_r  <= lane_r;
            shift_r <= shift_r;
        end
    end

    assign word      = {byte_data, shift_r};
    assign word_done = byte_valid && (lane_r == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, checksummed byte frame and writes it
// into instruction memory while holding the core in reset.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [LEN_W:0] MAX_WORDS = {{LEN_W{1'b0}}, 1'b1} << ADDR_W;

    state_t             state_r;
    logic [7:0]         sum_r;
    logic [7:0]         len_lo_r;
    logic [LEN_W-1:0]   len_r;
    logic [LEN_W-1:0]   idx_r;

    logic               accept_s;
    logic               data_acc_s;
    logic               clr_s;
    logic [LEN_W-1:0]   len_s;
    logic               too_long_s;
    logic [31:0]        asm_word_s;
    logic               asm_done_s;

    assign accept_s   = rx_valid && rx_ready;
    assign data_acc_s = accept_s && (state_r == ST_DATA);
    assign clr_s      = (state_r == ST_IDLE) && start;
    assign len_s      = {rx_data, len_lo_r};
    assign too_long_s = ({1'b0, len_s} > MAX_WORDS);

    word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr_s),
        .byte_valid (data_acc_s),
        .byte_data  (rx_data),
        .word       (asm_word_s),
        .word_done  (asm_done_s)
    );

    // Frame FSM with checksum, word index and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cpu_hold <= 1'b1;
            rx_ready <= 1'b0;
            we       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            waddr    <= {ADDR_W{1'b0}};
            wdata    <= 32'd0;
            sum_r    <= 8'd0;
            len_lo_r <= 8'd0;
            len_r    <= {LEN_W{1'b0}};
            idx_r    <= {LEN_W{1'b0}};
        end else begin
            we   <= 1'b0;
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r  <= ST_LEN_LO;
                        rx_ready <= 1'b1;
                        busy     <= 1'b1;
                        cpu_hold <= 1'b1;
                        err      <= 1'b0;
                        sum_r    <= 8'd0;
                        idx_r    <= {LEN_W{1'b0}};
                    end
                end
                ST_LEN_LO: begin
                    if (accept_s) begin
                        len_lo_r <= rx_data;
                        sum_r    <= sum8(sum_r, rx_data);
                        state_r  <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (accept_s) begin
                        sum_r <= sum8(sum_r, rx_data);
                        len_r <= len_s;
                        if (len_s == {LEN_W{1'b0}}) begin
                            state_r <= ST_SUM;
                        end else if (too_long_s) begin
                            state_r  <= ST_IDLE;
                            rx_ready <= 1'b0;
                            busy     <= 1'b0;
                            cpu_hold <= 1'b1;
                            err      <= 1'b1;
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept_s) begin
                        sum_r <= sum8(sum_r, rx_data);
                    end
                    // Write issues while the next word keeps assembling.
                    if (asm_done_s) begin
                        we    <= 1'b1;
                        waddr <= idx_r[ADDR_W-1:0];
                        wdata <= asm_word_s;
                        idx_r <= idx_r + 16'd1;
                        if (idx_r == (len_r - 16'd1)) begin
                            state_r <= ST_SUM;
                        end
                    end
                end
                ST_SUM: begin
                    if (accept_s) begin
                        state_r  <= ST_IDLE;
                        rx_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (rx_data == sum_r) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            err      <= 1'b1;
                            cpu_hold <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    rx_ready <= 1'b0;
                    busy     <= 1'b0;
                    cpu_hold <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad checksum, zero and oversize length,
// mid-frame reset, and a 16-word frame with gapped rx_valid and stray starts.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        we;
    logic [9:0]  waddr;
    logic [31:0] wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    logic [9:0]  mon_addr[$];
    logic [31:0] mon_data[$];
    logic [7:0]  frm[$];

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .we(we), .waddr(waddr), .wdata(wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
    );

    always @(negedge clk) begin
        if (we) begin
            mon_addr.push_back(waddr);
            mon_data.push_back(wdata);
        end
        if (done) done_cnt++;
    end

    task automatic send_byte(input logic [7:0] b);
        int  t;
        logic acc;
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        do begin
            acc = rx_ready;
            @(negedge clk);
            t++;
        end while (!acc && t < 50);
        rx_valid = 1'b0;
        if (!acc) begin
            n_checks++;
            $display("FAIL rx_timeout: byte %h not accepted within 50 cycles", b);
        end
    endtask

    task automatic send_frame();
        foreach (frm[i]) send_byte(frm[i]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clear_mon();
        mon_addr.delete();
        mon_data.delete();
        done_cnt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; rx_valid = 1'b1; rx_data = 8'hFF;
        repeat (2) @(negedge clk);
        n_checks++; if (rx_ready !== 1'b0) $display("FAIL rst_rx_ready: got %b want 0", rx_ready); else n_pass++;
        n_checks++; if (we !== 1'b0) $display("FAIL rst_we: got %b want 0", we); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else n_pass++;
        n_checks++; if (cpu_hold !== 1'b1) $display("FAIL rst_cpu_hold: got %b want 1", cpu_hold); else n_pass++;
        n_checks++; if (waddr !== 10'd0) $display("FAIL rst_waddr: got %h want 0", waddr); else n_pass++;
        n_checks++; if (wdata !== 32'd0) $display("FAIL rst_wdata: got %h want 0", wdata); else n_pass++;
        rst = 1'b0; start = 1'b0; rx_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_dominates_start: busy got %b want 0", busy); else n_pass++;
    endtask

    task automatic run_two_word(input logic [7:0] sum_byte);
        frm = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        pulse_start();
        send_frame();
        send_byte(sum_byte);
    endtask

    task automatic check_two_words(input string tag);
        n_checks++; if (mon_addr.size() !== 2) $display("FAIL %s_we_count: got %0d want 2", tag, mon_addr.size()); else n_pass++;
        n_checks++; if (mon_addr[0] !== 10'd0 || mon_data[0] !== 32'h00000013)
            $display("FAIL %s_word0: got %h@%h want 00000013@000", tag, mon_data[0], mon_addr[0]); else n_pass++;
        n_checks++; if (mon_addr[1] !== 10'd1 || mon_data[1] !== 32'h00100093)
            $display("FAIL %s_word1: got %h@%h want 00100093@001", tag, mon_data[1], mon_addr[1]); else n_pass++;
    endtask

    task automatic test_load_ok();
        clear_mon();
        pulse_start();
        n_checks++; if (busy !== 1'b1 || rx_ready !== 1'b1 || cpu_hold !== 1'b1)
            $display("FAIL start_state: busy/rx_ready/hold got %b%b%b want 111", busy, rx_ready, cpu_hold); else n_pass++;
        frm = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        send_frame();
        send_byte(8'hB8);
        n_checks++; if (done !== 1'b1) $display("FAIL ok_done: got %b want 1", done); else n_pass++;
        n_checks++; if (busy !== 1'b0 || cpu_hold !== 1'b0 || err !== 1'b0)
            $display("FAIL ok_status: busy/hold/err got %b%b%b want 000", busy, cpu_hold, err); else n_pass++;
        repeat (3) @(negedge clk);
        check_two_words("ok");
        n_checks++; if (done_cnt !== 1) $display("FAIL ok_done_once: got %0d want 1", done_cnt); else n_pass++;
        n_checks++; if (cpu_hold !== 1'b0 || rx_ready !== 1'b0)
            $display("FAIL ok_after: hold/rx_ready got %b%b want 00", cpu_hold, rx_ready); else n_pass++;
    endtask

    task automatic test_bad_sum();
        clear_mon();
        run_two_word(8'h00);
        repeat (3) @(negedge clk);
        check_two_words("bad");
        n_checks++; if (done_cnt !== 0) $display("FAIL bad_no_done: got %0d want 0", done_cnt); else n_pass++;
        n_checks++; if (err !== 1'b1 || cpu_hold !== 1'b1 || busy !== 1'b0)
            $display("FAIL bad_status: err/hold/busy got %b%b%b want 110", err, cpu_hold, busy); else n_pass++;
    endtask

    task automatic test_zero_len();
        clear_mon();
        pulse_start();
        n_checks++; if (err !== 1'b0) $display("FAIL start_clears_err: got %b want 0", err); else n_pass++;
        frm = '{8'h00, 8'h00, 8'h00};
        send_frame();
        n_checks++; if (done !== 1'b1) $display("FAIL zero_done: got %b want 1", done); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if (mon_addr.size() !== 0) $display("FAIL zero_we_count: got %0d want 0", mon_addr.size()); else n_pass++;
        n_checks++; if (err !== 1'b0 || cpu_hold !== 1'b0)
            $display("FAIL zero_status: err/hold got %b%b want 00", err, cpu_hold); else n_pass++;
    endtask

    task automatic test_too_long();
        pulse_start();
        send_byte(8'hFF);
        send_byte(8'hFF);
        n_checks++; if (err !== 1'b1 || busy !== 1'b0 || rx_ready !== 1'b0 || cpu_hold !== 1'b1)
            $display("FAIL len_ffff: err/busy/rdy/hold got %b%b%b%b want 1001", err, busy, rx_ready, cpu_hold); else n_pass++;
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h04);
        n_checks++; if (err !== 1'b1 || busy !== 1'b0)
            $display("FAIL len_1025: err/busy got %b%b want 10", err, busy); else n_pass++;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h04);
        n_checks++; if (err !== 1'b0 || busy !== 1'b1 || rx_ready !== 1'b1)
            $display("FAIL len_1024: err/busy/rdy got %b%b%b want 011", err, busy, rx_ready); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid();
        clear_mon();
        pulse_start();
        frm = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
        send_frame();
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (rx_ready !== 1'b0 || we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || cpu_hold !== 1'b1)
            $display("FAIL mid_rst_ctrl: rdy/we/busy/done/err/hold got %b%b%b%b%b%b want 000001",
                     rx_ready, we, busy, done, err, cpu_hold); else n_pass++;
        n_checks++; if (waddr !== 10'd0 || wdata !== 32'd0)
            $display("FAIL mid_rst_bus: got %h@%h want 0@0", wdata, waddr); else n_pass++;
        rst = 1'b0;
        n_checks++; if (mon_addr.size() !== 1 || mon_data[0] !== 32'h00000013)
            $display("FAIL mid_rst_kept: got %0d writes first %h want 1 00000013", mon_addr.size(), mon_data[0]); else n_pass++;
        clear_mon();
        run_two_word(8'hB8);
        repeat (3) @(negedge clk);
        check_two_words("fresh");
        n_checks++; if (done_cnt !== 1) $display("FAIL fresh_done: got %0d want 1", done_cnt); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w[16];
        logic [7:0]  s;
        int          k;
        clear_mon();
        frm = '{8'h10, 8'h00};
        s = 8'h10;
        for (int i = 0; i < 16; i++) begin
            exp_w[i] = 32'h01030507 * (i + 1) + 32'hA5000000;
            for (int j = 0; j < 4; j++) begin
                frm.push_back(exp_w[i][8*j +: 8]);
                s = s + exp_w[i][8*j +: 8];
            end
        end
        frm.push_back(s);
        pulse_start();
        k = 0;
        foreach (frm[i]) begin
            if (k == 20 || $urandom_range(0, 1) == 1) begin
                rx_valid = 1'b0;
                start = (k == 20 || k % 7 == 3);
                @(negedge clk);
                start = 1'b0;
            end
            send_byte(frm[i]);
            k++;
        end
        repeat (3) @(negedge clk);
        n_checks++; if (mon_addr.size() !== 16) $display("FAIL b2b_we_count: got %0d want 16", mon_addr.size()); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (mon_addr[i] !== 10'(i) || mon_data[i] !== exp_w[i])
                $display("FAIL b2b_word%0d: got %h@%h want %h@%h", i, mon_data[i], mon_addr[i], exp_w[i], 10'(i));
            else n_pass++;
        end
        n_checks++; if (done_cnt !== 1) $display("FAIL b2b_done_once: got %0d want 1", done_cnt); else n_pass++;
        n_checks++; if (err !== 1'b0 || cpu_hold !== 1'b0)
            $display("FAIL b2b_status: err/hold got %b%b want 00", err, cpu_hold); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        @(negedge clk);
        test_reset();
        test_load_ok();
        test_bad_sum();
        test_zero_len();
        test_too_long();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: ADDR_W, 10, instruction-memory word-address width; capacity 2^ADDR_W words.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  single-cycle request to begin a load.
REQ-005 Port: rx_valid  input  1  byte-stream source has a byte.
REQ-006 Port: rx_data  input  8  byte-stream data.
REQ-007 Port: rx_ready  output  1  loader accepts a byte this cycle; transfer occurs when rx_valid && rx_ready.
REQ-008 Port: we  output  1  instruction-memory write strobe.
REQ-009 Port: waddr  output  ADDR_W  instruction-memory word address.
REQ-010 Port: wdata  output  32  instruction word.
REQ-011 Port: cpu_hold  output  1  holds the core in reset while high.
REQ-012 Port: busy  output  1  load in progress.
REQ-013 Port: done  output  1  one-cycle pulse on successful load.
REQ-014 Port: err  output  1  sticky error flag for the last load.

Function
REQ-015 Frame format SHALL be: LEN_LO, LEN_HI (N words, 16-bit little-endian), 4*N data bytes, one SUM byte.
REQ-016 FSM states SHALL be IDLE, LEN_LO, LEN_HI, DATA, SUM.
REQ-017 IDLE: rx_ready=0; start=1 -> LEN_LO next cycle, busy=1, cpu_hold=1, err=0, running sum=0, word index=0.
REQ-018 start SHALL be ignored in every state except IDLE.
REQ-019 rx_ready SHALL be 1 in LEN_LO, LEN_HI, DATA and SUM; without rx_valid, state is held indefinitely (no timeout).
REQ-020 LEN_HI accept: N==0 -> SUM; N > 2^ADDR_W -> IDLE with err=1, busy=0, cpu_hold=1; otherwise -> DATA.
REQ-021 DATA: bytes assemble little-endian (first byte = bits 7:0) using a 2-bit lane counter.
REQ-022 On acceptance of lane-3 byte: next cycle we=1 for exactly one cycle, waddr=word index, wdata=assembled word; index increments.
REQ-023 Byte acceptance SHALL continue during the write cycle; the assembly register is independent of wdata (zero-bubble throughput, 1 byte/cycle).
REQ-024 After the Nth word's lane-3 byte -> SUM.
REQ-025 Running sum SHALL be the 8-bit modulo-256 sum of LEN_LO, LEN_HI and all data bytes; wraps silently.
REQ-026 SUM accept: byte == sum -> done=1 next cycle for one cycle, busy=0, cpu_hold=0 from that cycle; mismatch -> err=1, busy=0, cpu_hold=1, no done; both -> IDLE.
REQ-027 cpu_hold SHALL stay 0 after success until the next accepted start; err SHALL stay until next accepted start or reset.
REQ-028 we SHALL be 0 whenever no word is being written; waddr/wdata hold their last value otherwise.
REQ-029 Words written before an error or reset are not rolled back.

Reset
REQ-030 rst=1 at any edge, including mid-frame, SHALL force: state IDLE, cpu_hold=1, rx_ready=0, we=0, busy=0, done=0, err=0, waddr=0, wdata=0, sum=0, lane=0, index=0.
REQ-031 rst SHALL dominate start and rx_valid in the same cycle.

Structure
REQ-032 FSM state encoding and the frame-length width constant (16) SHALL live in the shared processor package.
REQ-033 Byte-to-word assembly (lane counter, shift register, word-complete flag) SHALL be one sub-module, word_assembler; FSM, sum and address counter stay in imem_loader.

Verification
REQ-034 start; bytes 02 00 13 00 00 00 93 00 10 00 B8 -> we at addr 0 wdata 0x00000013, addr 1 wdata 0x00100093, then done pulse, cpu_hold=0, err=0.
REQ-035 Same frame with SUM=0x00 -> exactly two we pulses, no done, err=1, cpu_hold=1.
REQ-036 start; bytes 00 00 00 -> zero we pulses, done=1; N=0xFFFF with ADDR_W=10 -> err=1 after LEN_HI, return to IDLE.
REQ-037 rst asserted after 6 data bytes of a 2-word frame -> next cycle all outputs at reset values; fresh frame then loads correctly from addr 0.
REQ-038 rx_valid randomly toggled (50%) across a 16-word frame -> 16 we pulses with correct addr/data order, done once; start pulses mid-frame have no effect.
